// File: rtl/mvb_change_detect.sv
`default_nettype none
// ============================================================================
// Module   : mvb_change_detect
// Brief    : MVB stage flagging value changes between successive valid items
//            and counting the run of identical items that preceded each one.
// Revision : 1.0 - initial release
// ============================================================================
module mvb_change_detect #(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_clear,
    input  logic [ITEMS*ITEM_WIDTH-1:0]     i_rx_data,
    input  logic [ITEMS-1:0]                i_rx_vld,
    input  logic                            i_rx_src_rdy,
    output logic                            o_rx_dst_rdy,
    output logic [ITEMS*ITEM_WIDTH-1:0]     o_tx_data,
    output logic [ITEMS-1:0]                o_tx_vld,
    output logic [ITEMS-1:0]                o_tx_change,
    output logic [ITEMS*CNT_WIDTH-1:0]      o_tx_run,
    output logic                            o_tx_src_rdy,
    input  logic                            i_tx_dst_rdy
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO = '0;

    logic                            r_tx_src_rdy;
    logic [ITEMS*ITEM_WIDTH-1:0]     r_tx_data;
    logic [ITEMS-1:0]                r_tx_vld;
    logic [ITEMS-1:0]                r_tx_change;
    logic [ITEMS*CNT_WIDTH-1:0]      r_tx_run;
    logic                            r_prev_vld;
    logic [ITEM_WIDTH-1:0]           r_prev_data;
    logic [CNT_WIDTH-1:0]            r_prev_run;

    logic                            w_rx_dst_rdy;
    logic                            w_accept;
    logic                            w_load;
    logic [ITEMS:0]                  w_p_vld;
    logic [ITEM_WIDTH-1:0]           w_p_data [ITEMS+1];
    logic [CNT_WIDTH-1:0]            w_p_run  [ITEMS+1];
    logic [ITEMS-1:0]                w_change;
    logic [ITEMS*CNT_WIDTH-1:0]      w_run;

    assign w_rx_dst_rdy = i_tx_dst_rdy | ~r_tx_src_rdy;
    assign w_accept     = i_rx_src_rdy & w_rx_dst_rdy;
    // Empty words are consumed but never produce an output word.
    assign w_load       = w_accept & (|i_rx_vld);

    // CLEAR forgets history before the current word is evaluated.
    assign w_p_vld[0]  = r_prev_vld & ~i_clear;
    assign w_p_data[0] = r_prev_data;
    assign w_p_run[0]  = i_clear ? c_CNT_ZERO : r_prev_run;

    generate
        for (genvar gi = 0; gi < ITEMS; gi++) begin : g_chain
            logic [ITEM_WIDTH-1:0] w_item;
            logic [CNT_WIDTH-1:0]  w_run_inc;
            logic [CNT_WIDTH-1:0]  w_run_item;

            assign w_item       = i_rx_data[gi*ITEM_WIDTH +: ITEM_WIDTH];
            assign w_change[gi] = i_rx_vld[gi] & (~w_p_vld[gi] | (w_item != w_p_data[gi]));
            assign w_run_inc    = (&w_p_run[gi]) ? w_p_run[gi] : (w_p_run[gi] + c_CNT_ONE);
            assign w_run_item   = (i_rx_vld[gi] && !w_change[gi]) ? w_run_inc : c_CNT_ZERO;
            assign w_run[gi*CNT_WIDTH +: CNT_WIDTH] = w_run_item;

            assign w_p_vld[gi+1]  = w_p_vld[gi] | i_rx_vld[gi];
            assign w_p_data[gi+1] = i_rx_vld[gi] ? w_item     : w_p_data[gi];
            assign w_p_run[gi+1]  = i_rx_vld[gi] ? w_run_item : w_p_run[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_src_rdy <= 1'b0;
            r_tx_data    <= '0;
            r_tx_vld     <= '0;
            r_tx_change  <= '0;
            r_tx_run     <= '0;
            r_prev_vld   <= 1'b0;
            r_prev_data  <= '0;
            r_prev_run   <= '0;
        end else begin
            if (w_load) begin
                r_tx_src_rdy <= 1'b1;
                r_tx_data    <= i_rx_data;
                r_tx_vld     <= i_rx_vld;
                r_tx_change  <= w_change;
                r_tx_run     <= w_run;
                r_prev_vld   <= w_p_vld[ITEMS];
                r_prev_data  <= w_p_data[ITEMS];
                r_prev_run   <= w_p_run[ITEMS];
            end else begin
                if (i_tx_dst_rdy) begin
                    r_tx_src_rdy <= 1'b0;
                end
                if (i_clear) begin
                    r_prev_vld <= 1'b0;
                    r_prev_run <= '0;
                end
            end
        end
    end

    assign o_rx_dst_rdy = w_rx_dst_rdy;
    assign o_tx_src_rdy = r_tx_src_rdy;
    assign o_tx_data    = r_tx_data;
    assign o_tx_vld     = r_tx_vld;
    assign o_tx_change  = r_tx_change;
    assign o_tx_run     = r_tx_run;

endmodule
`default_nettype wire
